// File: rtl/filter_writeback.sv
// Collects the filtered pixel stream into a raster-ordered frame buffer,
// tracking frame progress and a running checksum, with a registered host read port.
module filter_writeback #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wr,
  input  logic [DW-1:0]    cl_pixel,
  output logic             busy,
  output logic             frame_done,
  output logic             done_flag,
  output logic             overflow,
  output logic [AW:0]      pix_count,
  output logic [DW+AW-1:0] checksum,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] mem [2**AW];

  logic start_take;
  logic accept;
  logic last_pix;
  logic drop;

  // Pixels arrive strictly in raster order, so the low bits of pix_count
  // double as the linear write address; no row*IMG_W product is needed.
  logic [AW-1:0] wr_addr;
  assign wr_addr = pix_count[AW-1:0];

  always_comb begin
    state_next = state;
    start_take = 1'b0;
    accept     = 1'b0;
    last_pix   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_take = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (wr) begin
          accept = 1'b1;
          if (pix_count == LAST_IDX) begin
            last_pix   = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    drop = wr && !accept;
  end

  assign busy = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      done_flag  <= 1'b0;
      overflow   <= 1'b0;
      pix_count  <= '0;
      checksum   <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= last_pix;
      rd_valid   <= rd_en;
      if (start_take) begin
        pix_count <= '0;
        checksum  <= '0;
        done_flag <= 1'b0;
      end else if (accept) begin
        pix_count <= pix_count + 1'b1;
        checksum  <= checksum + {{AW{1'b0}}, cl_pixel};
        if (last_pix) done_flag <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
      // Non-blocking update gives read-before-write on same-address collisions.
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  // Buffer contents survive reset so a partial frame stays readable.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= cl_pixel;
  end

endmodule

// File: tb/tb_filter_writeback.sv
// Table-driven bench for filter_writeback with a read-data scoreboard.
module tb_filter_writeback;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             wr = 1'b0;
  logic [DW-1:0]    cl_pixel = '0;
  logic             busy;
  logic             frame_done;
  logic             done_flag;
  logic             overflow;
  logic [AW:0]      pix_count;
  logic [DW+AW-1:0] checksum;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;

  filter_writeback #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wr         (wr),
    .cl_pixel   (cl_pixel),
    .busy       (busy),
    .frame_done (frame_done),
    .done_flag  (done_flag),
    .overflow   (overflow),
    .pix_count  (pix_count),
    .checksum   (checksum),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem [IMG_W*IMG_H];

  typedef struct {
    logic             start;
    logic             wr;
    logic [DW-1:0]    px;
    logic             e_busy;
    logic             e_fd;
    logic             e_done;
    logic             e_ovf;
    logic [AW:0]      e_cnt;
    logic [DW+AW-1:0] e_cks;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic s, input logic w, input logic [DW-1:0] px,
                              input logic b, input logic fd, input logic dn, input logic ov,
                              input int cnt, input int cks);
    vec_t v;
    v.start = s; v.wr = w; v.px = px;
    v.e_busy = b; v.e_fd = fd; v.e_done = dn; v.e_ovf = ov;
    v.e_cnt = (AW+1)'(cnt);
    v.e_cks = (DW+AW)'(cks);
    vecs.push_back(v);
  endfunction

  // driver: one table row per clock, outputs compared #1 after the edge
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr && $isunknown(vecs[i].px)) begin
        n_total++;
        $display("FAIL %s[%0d] x_pixel: got %b, expected known value", tag, i, vecs[i].px);
      end
      start    = vecs[i].start;
      wr       = vecs[i].wr;
      cl_pixel = vecs[i].px;
      tick();
      start = 1'b0;
      wr    = 1'b0;
      chk($sformatf("%s[%0d].busy", tag, i),       32'(busy),       32'(vecs[i].e_busy));
      chk($sformatf("%s[%0d].frame_done", tag, i), 32'(frame_done), 32'(vecs[i].e_fd));
      chk($sformatf("%s[%0d].done_flag", tag, i),  32'(done_flag),  32'(vecs[i].e_done));
      chk($sformatf("%s[%0d].overflow", tag, i),   32'(overflow),   32'(vecs[i].e_ovf));
      chk($sformatf("%s[%0d].pix_count", tag, i),  32'(pix_count),  32'(vecs[i].e_cnt));
      chk($sformatf("%s[%0d].checksum", tag, i),   32'(checksum),   32'(vecs[i].e_cks));
    end
    vecs.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"},       32'(busy),       0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".done_flag"},  32'(done_flag),  0);
    chk({tag, ".overflow"},   32'(overflow),   0);
    chk({tag, ".pix_count"},  32'(pix_count),  0);
    chk({tag, ".checksum"},   32'(checksum),   0);
    chk({tag, ".rd_data"},    32'(rd_data),    0);
    chk({tag, ".rd_valid"},   32'(rd_valid),   0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check_reset(tag);
  endtask

  // back-to-back reads of addresses lo..hi
  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back(exp_mem[a]);
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  // scoreboard: every rd_valid cycle pops one expected datum
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 rd_data=0x%0h, expected no read", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int cks;
    logic [DW-1:0] p5 [5];
    p5[0] = 8'd10; p5[1] = 8'd20; p5[2] = 8'd30; p5[3] = 8'd40; p5[4] = 8'd50;

    // power-on reset
    tick();
    tick();
    rst_n = 1'b0;
    check_reset("reset");

    // full frame, back-to-back pixels 1..12
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    cks = 0;
    for (int i = 1; i <= 12; i++) begin
      cks += i;
      add(0, 1, DW'(i), i < 12, i == 12, i == 12, 0, i, cks);
      exp_mem[i-1] = DW'(i);
    end
    add(0, 0, 0, 0, 0, 1, 0, 12, 78);
    run_vecs("full");
    read_range(0, 11);

    // gapped stream, wr every third cycle
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    cks = 0;
    for (int i = 1; i <= 12; i++) begin
      cks += i;
      add(0, 1, DW'(i), i < 12, i == 12, i == 12, 0, i, cks);
      add(0, 0, 0, i < 12, 0, i == 12, 0, i, cks);
      add(0, 0, 0, i < 12, 0, i == 12, 0, i, cks);
    end
    run_vecs("gap");
    read_range(0, 11);

    // write after DONE is dropped; restart keeps overflow sticky
    add(0, 1, 8'hFF, 0, 0, 1, 1, 12, 78);
    add(0, 0, 0, 0, 0, 1, 1, 12, 78);
    run_vecs("ovf");
    read_range(0, 11);
    add(1, 0, 0, 1, 0, 0, 1, 0, 0);
    run_vecs("restart");

    // start and wr in the same cycle from IDLE
    do_reset("rst_a");
    add(1, 1, 8'hAA, 1, 0, 0, 1, 0, 0);
    add(0, 1, 8'h55, 1, 0, 0, 1, 1, 8'h55);
    run_vecs("coll");
    exp_mem[0] = 8'h55;
    read_range(0, 0);

    // reset after five pixels; buffer keeps them
    do_reset("rst_b");
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    cks = 0;
    for (int i = 0; i < 5; i++) begin
      cks += int'(p5[i]);
      add(0, 1, p5[i], 1, 0, 0, 0, i + 1, cks);
      exp_mem[i] = p5[i];
    end
    run_vecs("mid");
    do_reset("mid_rst");
    read_range(4, 4);
    add(0, 1, 8'h77, 0, 0, 0, 1, 0, 0);
    run_vecs("post_rst_idle");
    read_range(0, 4);

    // read-before-write on address 3
    do_reset("rst_c");
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 8'd1, 1, 0, 0, 0, 1, 1);
    add(0, 1, 8'd2, 1, 0, 0, 0, 2, 3);
    add(0, 1, 8'd3, 1, 0, 0, 0, 3, 6);
    add(0, 1, 8'h11, 1, 0, 0, 0, 4, 6 + 8'h11);
    run_vecs("prefill");
    exp_mem[0] = 8'd1; exp_mem[1] = 8'd2; exp_mem[2] = 8'd3; exp_mem[3] = 8'h11;
    do_reset("rst_d");
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 8'd4, 1, 0, 0, 0, 1, 4);
    add(0, 1, 8'd5, 1, 0, 0, 0, 2, 9);
    add(0, 1, 8'd6, 1, 0, 0, 0, 3, 15);
    run_vecs("rw_pre");
    exp_mem[0] = 8'd4; exp_mem[1] = 8'd5; exp_mem[2] = 8'd6;
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    exp_q.push_back(exp_mem[3]);
    add(0, 1, 8'h22, 1, 0, 0, 0, 4, 15 + 8'h22);
    run_vecs("rw_coll");
    rd_en = 1'b0;
    exp_mem[3] = 8'h22;
    read_range(3, 3);

    tick();
    chk("rd_queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/filter_writeback.md
# filter_writeback

Result-side collector for the 3x3 parallel filter datapath: consumes the filtered pixel stream (`wr` strobe plus `cl_pixel`) the filter core produces, and writes each pixel in raster order into an internal output frame buffer. It tracks column and row position, signals frame completion, and keeps a running checksum. A registered host read port lets the host or testbench retrieve the filtered image. It sits downstream of the filter, mirroring the window-serving memory on the input side.

## Interface
- `IMG_W`, 64: output image width in pixels.
- `IMG_H`, 64: output image height in pixels.
- `DW`, 8: pixel width.
- `AW`, 12: buffer address width; must satisfy 2^AW >= IMG_W*IMG_H.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-high: `rst_n`=1 at a rising edge resets the block.
- `start`  in  1  arms collection of one frame.
- `wr`  in  1  pixel strobe from the filter; one pixel per asserted cycle.
- `cl_pixel`  in  DW  filtered pixel, qualified by `wr`.
- `busy`  out  1  high while in COLLECT.
- `frame_done`  out  1  one-cycle pulse when the last pixel of the frame is written.
- `done_flag`  out  1  sticky completion flag, cleared by `start` or reset.
- `overflow`  out  1  sticky; set when a `wr` is dropped.
- `pix_count`  out  AW+1  pixels accepted in the current frame.
- `checksum`  out  DW+AW  modulo-2^(DW+AW) sum of accepted pixels.
- `rd_en`  in  1  host read request.
- `rd_addr`  in  AW  host read address (raster index row*IMG_W+col).
- `rd_data`  out  DW  read data, registered.
- `rd_valid`  out  1  high one cycle after an `rd_en` cycle.

## Operation
- States: IDLE, COLLECT, DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1: go to COLLECT. Clear `col`, `row`, `pix_count`, `checksum` and `done_flag`. `overflow` is not cleared.
- `start` during COLLECT is ignored.
- COLLECT with `wr`=1:
  - Write `mem[row*IMG_W+col]` = `cl_pixel`. The implementation keeps a linear write address counter rather than using a multiplier.
  - `pix_count`+1, `checksum` += zero-extended `cl_pixel`.
  - `col`+1; when `col`=IMG_W-1, `col` wraps to 0 and `row`+1.
- Accepting the pixel with `pix_count`=IMG_W*IMG_H-1: the state goes to DONE, `frame_done` pulses, and `done_flag` is set.
- `wr` in IDLE or DONE: the pixel is dropped, the memory is unchanged, and `overflow` is set.
- `wr` in the same cycle as an accepted `start`: the pixel is dropped and `overflow` is set. `start` takes priority.
- `wr` with `cl_pixel` containing X is not allowed; the bench flags it.
- Host read port:
  - Operates in any state.
  - `rd_data` = `mem[rd_addr]` from the `rd_en` cycle; it holds its value when `rd_en`=0.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
  - `rd_addr` >= IMG_W*IMG_H returns an undefined value; the bench does not check it.
- Reset mid-frame: the state returns to IDLE and all counters and flags clear. Buffer contents are not cleared. Pixels written so far remain readable.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `done_flag`=0, `overflow`=0, `pix_count`=0, `checksum`=0, `rd_data`=0, `rd_valid`=0.
- `start` sampled at edge N: `busy`=1 after N. The first `wr` is accepted at edge N+1 at the earliest.
- Write latency: a pixel accepted at edge N is in memory after N and is readable with `rd_en` at edge N+1, giving `rd_data` after N+1.
- Final pixel accepted at edge N, after N:
  - `frame_done`=1 for exactly one cycle;
  - `busy`=0, `done_flag`=1;
  - `pix_count`=IMG_W*IMG_H.
- Throughput: one pixel per cycle with `wr` held high continuously; no back-pressure.
- `rd_valid` follows `rd_en` by one cycle. Back-to-back reads give one datum per cycle.

## Test plan
Bench parameters: IMG_W=4, IMG_H=3, AW=4.
- Full frame: `start`, then 12 back-to-back `wr` with pixels 1..12. Required: `frame_done` pulses one cycle after the 12th pixel, `pix_count`=12, `checksum`=78, `done_flag`=1. Reading addresses 0..11 returns 1..12.
- Gapped stream: the same 12 pixels with `wr` asserted every third cycle. Required: identical memory contents and `checksum`. `busy` stays high until the 12th pixel is accepted.
- Overflow: 13th `wr` (value 0xFF) after DONE. Required: `overflow`=1 and `mem[0..11]` unchanged. A new `start` clears `done_flag` but `overflow` stays 1.
- Start/write collision: `start` and `wr`=0xAA in the same cycle from IDLE. Required: 0xAA is dropped, `overflow`=1, `pix_count`=0. The next `wr`=0x55 lands at address 0.
- Reset mid-frame: `rst_n`=1 after 5 pixels (10,20,30,40,50). Required: all outputs at reset values and the state is IDLE. Reading address 4 returns 50.
- Read/write collision: pre-fill address 3 with 0x11. In the next frame, write 0x22 to address 3 while `rd_en` reads address 3 in the same cycle. Required: `rd_data`=0x11; a read on the following cycle returns 0x22.
